shift_seq_reg: RTL and testbench
================================

SHIFT_SEQ_REG -- requirements
Module: shift_seq_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning register width in bits (legal range 2..64).
REQ-002 SHALL have derived localparam CW = $clog2(WIDTH+1), meaning the shift-amount and counter width.
REQ-003 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ld  input  1  parallel load request.
REQ-006 SHALL have port par_in  input  WIDTH  parallel load data.
REQ-007 SHALL have port start  input  1  begin multi-cycle shift operation.
REQ-008 SHALL have port mode  input  3  operation: 000 SHL, 001 SHR, 010 ROL, 011 ROR, 100 ASR, others reserved.
REQ-009 SHALL have port amt  input  CW  number of single-bit steps requested.
REQ-010 SHALL have port ser_in_l  input  1  bit entering MSB on SHR.
REQ-011 SHALL have port ser_in_r  input  1  bit entering LSB on SHL.
REQ-012 SHALL have port par_out  output  WIDTH  register contents.
REQ-013 SHALL have ports MSB_out and LSB_out  output  1 each  par_out[WIDTH-1] and par_out[0].
REQ-014 SHALL have ports busy and done  output  1 each  operation in progress; one-cycle completion pulse.

Function
REQ-015 FSM SHALL have states IDLE, SHIFT, DONE.
REQ-016 In IDLE or DONE, ld=1 SHALL load par_in at the next edge, go to IDLE; ld has priority over start.
REQ-017 In IDLE or DONE, start=1 with ld=0 SHALL latch mode and min(amt, WIDTH) into counter; count>0 -> SHIFT, count=0 -> DONE with par_out unchanged.
REQ-018 In SHIFT, each edge SHALL perform exactly one step per latched mode and decrement counter; the edge that reaches 0 moves to DONE.
REQ-019 Steps: SHL {par_out[W-2:0],ser_in_r}; SHR {ser_in_l,par_out[W-1:1]}; ROL/ROR rotate by one; ASR replicates MSB; reserved modes hold value but still count.
REQ-020 Serial inputs SHALL be sampled on each step edge, not latched at start.
REQ-021 Latency: start sampled at edge E0 with n>0 -> steps at E1..En, done=1 for the cycle after En; n=0 -> done=1 for the cycle after E0.
REQ-022 busy SHALL equal (state==SHIFT); done SHALL equal (state==DONE); never both high.
REQ-023 ld, start, amt, mode SHALL be ignored while busy=1.
REQ-024 DONE SHALL last exactly one cycle; back-to-back start from DONE SHALL be accepted with no idle gap.
REQ-025 amt > WIDTH SHALL saturate to WIDTH steps (SHL/SHR full flush, ROL/ROR identity).

Reset
REQ-026 rst=1 SHALL immediately force par_out=0, counter=0, latched mode=000, state IDLE, busy=0, done=0, including mid-operation.
REQ-027 First edge after rst deassertion SHALL behave as IDLE.

Structure
REQ-028 Package shift_seq_pkg SHALL hold the mode encodings and FSM state encodings.
REQ-029 One sub-module shift_step (combinational, WIDTH-parametrised, mode+serial in -> next value) SHALL implement the single-bit step.
REQ-030 Counter, FSM and register SHALL reside in shift_seq_reg; no latches, single clock domain.

Verification (WIDTH=16)
REQ-031 ld, par_in=16'h8001, then start mode=ROL amt=4 -> busy 4 cycles, par_out=16'h0018, done pulse one cycle.
REQ-032 Load 16'h8000, start mode=ASR amt=3 -> par_out=16'hF000; LSB_out=0, MSB_out=1.
REQ-033 Load 16'h00FF, start SHL amt=20 with ser_in_r=1 -> 16 steps, par_out=16'hFFFF.
REQ-034 start amt=0 -> busy never high, done high one cycle after start edge, par_out unchanged; ld during busy of another op -> ignored.
REQ-035 rst pulse during SHIFT after 2 of 5 steps -> par_out=0, busy=0, done=0 immediately; next start runs normally.
REQ-036 Two consecutive ops, start asserted in DONE cycle -> second op begins next edge, no extra idle cycle.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared encodings for the shift/sequence register: operation modes and FSM states.
package shift_seq_pkg;

  localparam logic [2:0] MODE_SHL = 3'b000;
  localparam logic [2:0] MODE_SHR = 3'b001;
  localparam logic [2:0] MODE_ROL = 3'b010;
  localparam logic [2:0] MODE_ROR = 3'b011;
  localparam logic [2:0] MODE_ASR = 3'b100;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

endpackage

// File: rtl/shift_step.sv
// Single-bit step of the shift register; purely combinational.
module shift_step
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] cur,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  output logic [WIDTH-1:0] nxt
);

  // Next register value for one step; reserved modes hold the value.
  always_comb begin
    nxt = cur;
    case (mode)
      MODE_SHL: nxt = {cur[WIDTH-2:0], ser_in_r};
      MODE_SHR: nxt = {ser_in_l, cur[WIDTH-1:1]};
      MODE_ROL: nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
      MODE_ROR: nxt = {cur[0], cur[WIDTH-1:1]};
      MODE_ASR: nxt = {cur[WIDTH-1], cur[WIDTH-1:1]};
      default:  nxt = cur;
    endcase
  end

endmodule

// File: rtl/shift_seq_reg.sv
// Multi-cycle shift/rotate register: parallel load, then one step per clock for a
// saturated step count, with busy during stepping and a one-cycle done pulse.
module shift_seq_reg
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int CW   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] par_in,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CW-1:0]    amt,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  output logic [WIDTH-1:0] par_out,
  output logic             MSB_out,
  output logic             LSB_out,
  output logic             busy,
  output logic             done
);

  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  logic [WIDTH-1:0] par_r;
  logic [WIDTH-1:0] step_s;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    amt_sat_s;
  logic [2:0]       mode_r;
  logic [1:0]       state_r;
  logic             busy_r;
  logic             done_r;

  function automatic logic [CW-1:0] sat_amt(input logic [CW-1:0] a);
    if (a > WIDTH_C) begin
      sat_amt = WIDTH_C;
    end else begin
      sat_amt = a;
    end
  endfunction

  assign amt_sat_s = sat_amt(amt);

  shift_step #(.WIDTH(WIDTH)) u_step (
    .mode     (mode_r),
    .cur      (par_r),
    .ser_in_l (ser_in_l),
    .ser_in_r (ser_in_r),
    .nxt      (step_s)
  );

  // FSM, step counter and data register; busy/done are kept as registers alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_r   <= {WIDTH{1'b0}};
      cnt_r   <= CNT_ZERO;
      mode_r  <= MODE_SHL;
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (ld) begin
            par_r   <= par_in;
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end else if (start) begin
            mode_r <= mode;
            cnt_r  <= amt_sat_s;
            if (amt_sat_s != CNT_ZERO) begin
              state_r <= ST_SHIFT;
              busy_r  <= 1'b1;
              done_r  <= 1'b0;
            end else begin
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          par_r <= step_s;
          cnt_r <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            state_r <= ST_SHIFT;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign par_out = par_r;
  assign MSB_out = par_r[WIDTH-1];
  assign LSB_out = par_r[0];
  assign busy    = busy_r;
  assign done    = done_r;

endmodule

// File: tb/tb_shift_seq_reg.sv
// Directed self-checking bench for shift_seq_reg at WIDTH=16.
module tb_shift_seq_reg;

  localparam int WIDTH = 16;
  localparam int CW    = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ld = 1'b0;
  logic [WIDTH-1:0] par_in = 16'h0000;
  logic             start = 1'b0;
  logic [2:0]       mode = 3'b000;
  logic [CW-1:0]    amt = 5'd0;
  logic             ser_in_l = 1'b0;
  logic             ser_in_r = 1'b0;
  logic [WIDTH-1:0] par_out;
  logic             MSB_out;
  logic             LSB_out;
  logic             busy;
  logic             done;

  int total = 0;
  int bad = 0;

  shift_seq_reg #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .ld       (ld),
    .par_in   (par_in),
    .start    (start),
    .mode     (mode),
    .amt      (amt),
    .ser_in_l (ser_in_l),
    .ser_in_r (ser_in_r),
    .par_out  (par_out),
    .MSB_out  (MSB_out),
    .LSB_out  (LSB_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [WIDTH-1:0] v);
    ld = 1'b1;
    par_in = v;
    tick();
    ld = 1'b0;
  endtask

  // Start an op and count busy cycles (bounded) until it ends.
  task automatic run_op(input string tag, input logic [2:0] m, input logic [CW-1:0] a,
                        input int exp_steps);
    int steps;
    int guard;
    mode = m;
    amt = a;
    start = 1'b1;
    tick();
    start = 1'b0;
    steps = 0;
    guard = 0;
    while (busy === 1'b1 && guard < 40) begin
      steps++;
      guard++;
      tick();
    end
    check({tag, "_steps"}, 64'(steps), 64'(exp_steps));
    check({tag, "_done"}, {63'd0, done}, 64'd1);
  endtask

  initial begin
    // reset state
    tick();
    tick();
    check("rst_par", 64'(par_out), 64'h0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    rst = 1'b0;

    // ROL 8001 by 4 with ld/start attempts while busy
    do_load(16'h8001);
    check("load", 64'(par_out), 64'h8001);
    mode = 3'b010;
    amt = 5'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("rol_busy", {63'd0, busy}, 64'd1);
      check("rol_nodone", {63'd0, done}, 64'd0);
      if (i == 1) begin
        ld = 1'b1;
        par_in = 16'h1234;
        start = 1'b1;
        mode = 3'b000;
        amt = 5'd1;
      end else begin
        ld = 1'b0;
        start = 1'b0;
      end
      tick();
    end
    ld = 1'b0;
    start = 1'b0;
    check("rol_par", 64'(par_out), 64'h0018);
    check("rol_done", {63'd0, done}, 64'd1);
    check("rol_busy_end", {63'd0, busy}, 64'd0);
    tick();
    check("rol_done_1cyc", {63'd0, done}, 64'd0);

    // ASR 8000 by 3
    do_load(16'h8000);
    run_op("asr", 3'b100, 5'd3, 3);
    check("asr_par", 64'(par_out), 64'hF000);
    check("asr_lsb", {63'd0, LSB_out}, 64'd0);
    check("asr_msb", {63'd0, MSB_out}, 64'd1);

    // SHL 00FF, amt 20 saturates to 16
    do_load(16'h00FF);
    ser_in_r = 1'b1;
    run_op("shl_sat", 3'b000, 5'd20, 16);
    check("shl_sat_par", 64'(par_out), 64'hFFFF);
    ser_in_r = 1'b0;

    // amt=0: no busy, done next cycle, value unchanged
    do_load(16'h1234);
    run_op("zero", 3'b000, 5'd0, 0);
    check("zero_par", 64'(par_out), 64'h1234);
    tick();
    check("zero_done_1cyc", {63'd0, done}, 64'd0);

    // SHR with ser_in_l changing between steps
    mode = 3'b001;
    amt = 5'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    ser_in_l = 1'b1;
    tick();
    check("shr_step1", 64'(par_out), 64'h891A);
    ser_in_l = 1'b0;
    tick();
    check("shr_step2", 64'(par_out), 64'h448D);
    check("shr_done", {63'd0, done}, 64'd1);

    // ROR amt 20 -> identity
    do_load(16'h0001);
    run_op("ror_sat", 3'b011, 5'd20, 16);
    check("ror_par", 64'(par_out), 64'h0001);

    // reserved mode holds but counts
    do_load(16'h00FF);
    run_op("rsv", 3'b111, 5'd3, 3);
    check("rsv_par", 64'(par_out), 64'h00FF);

    // reset after 2 of 5 steps
    mode = 3'b000;
    amt = 5'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("mid_par", 64'(par_out), 64'h03FC);
    rst = 1'b1;
    #1;
    check("mid_rst_par", 64'(par_out), 64'h0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_done", {63'd0, done}, 64'd0);
    tick();
    rst = 1'b0;
    do_load(16'h4001);
    run_op("post_rst", 3'b010, 5'd1, 1);
    check("post_rst_par", 64'(par_out), 64'h8002);

    // back-to-back: second start in DONE cycle
    do_load(16'h0001);
    run_op("b2b_a", 3'b000, 5'd2, 2);
    check("b2b_a_par", 64'(par_out), 64'h0004);
    mode = 3'b000;
    amt = 5'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b_busy", {63'd0, busy}, 64'd1);
    tick();
    check("b2b_par", 64'(par_out), 64'h0008);
    check("b2b_done", {63'd0, done}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
